// File: rtl/rv32i_pkg.sv
// Shared RV32I OP-IMM encoding constants and the skid-buffer state type.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_ADDI      = 3'b000;
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SLTI      = 3'b010;
    localparam logic [2:0] F3_SLTIU     = 3'b011;
    localparam logic [2:0] F3_XORI      = 3'b100;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
    localparam logic [2:0] F3_ORI       = 3'b110;
    localparam logic [2:0] F3_ANDI      = 3'b111;

    localparam logic [6:0] FUNCT7_SRA   = 7'b0100000;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLLI) || (f3 == F3_SRLI_SRAI);
    endfunction

    // Shifts carry funct7 in imm[11:5] and shamt in imm[4:0].
    function automatic logic [31:0] enc_op_imm(input logic [2:0]  f3,
                                               input logic        sub_sra,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  rs1,
                                               input logic [11:0] imm);
        logic [31:0] word;
        if (is_shift(f3))
            word = {(sub_sra ? FUNCT7_SRA : 7'b0), imm[4:0], rs1, f3, rd, OPC_OP_IMM};
        else
            word = {imm, rs1, f3, rd, OPC_OP_IMM};
        return word;
    endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// Two-entry FIFO skid buffer; in_ready is registered so it never depends on out_ready
// combinationally. Handshake: a word moves when valid and ready are both high at a rising edge.
module enc_skid_buf
    import rv32i_pkg::*;
#(
    parameter int             W        = 44,
    parameter logic [W-1:0]   RST_DATA = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         in_ready,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output buf_state_t   state_dbg
);

    buf_state_t   state, state_nxt;
    logic [W-1:0] head, head_nxt;
    logic [W-1:0] tail, tail_nxt;
    logic         pop;

    assign pop       = (state != BUF_EMPTY) && out_ready;
    assign dout      = head;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            BUF_EMPTY: begin
                if (push) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = din;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_nxt = BUF_TWO;
                        tail_nxt  = din;
                    end
                    2'b01: state_nxt = BUF_EMPTY;
                    2'b11: head_nxt  = din;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                // in_ready is low here, so push cannot coincide.
                if (pop) begin
                    state_nxt = BUF_ONE;
                    head_nxt  = tail;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            head     <= RST_DATA;
            tail     <= '0;
            in_ready <= 1'b1;
        end else if (clr) begin
            state    <= BUF_EMPTY;
            head     <= RST_DATA;
            tail     <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            in_ready <= (state_nxt != BUF_TWO);
        end
    end

endmodule

// File: rtl/insn_i_alu_encoder.sv
// RV32I OP-IMM encoder: validates field bundles, packs them, tags them with a wrapping
// byte address and queues them in a skid buffer. ENC_ERR_COUNT_EN adds a saturating err_cnt.
module insn_i_alu_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic              sub_sra,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [11:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
`ifdef ENC_ERR_COUNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));

    logic              acc;
    logic              illegal;
    logic              push;
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr_cnt;
    buf_state_t        buf_state;

    assign acc     = in_valid && in_ready && !clr;
    assign illegal = (is_shift(funct3) && (imm[11:5] != 7'd0))
                   || (sub_sra && (funct3 != F3_SRLI_SRAI));
    assign push    = acc && !illegal;
    assign word    = enc_op_imm(funct3, sub_sra, rd, rs1, imm);

    assign out_valid = (buf_state != BUF_EMPTY);

    enc_skid_buf #(
        .W        (32 + ADDR_W),
        .RST_DATA ({32'b0, BASE})
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .din       ({word, addr_cnt}),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .dout      ({insn, out_addr}),
        .state_dbg (buf_state)
    );

    // Illegal bundles are consumed without touching the address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            addr_cnt <= BASE;
        end else if (clr) begin
            err      <= 1'b0;
            addr_cnt <= BASE;
        end else begin
            err <= acc && illegal;
            if (push)
                addr_cnt <= (addr_cnt == LAST) ? BASE : addr_cnt + ADDR_W'(4);
        end
    end

`ifdef ENC_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (clr)
            err_cnt <= 8'd0;
        else if (err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule
